// File: rtl/player_input_ctrl.sv
// Direction-input front end: debounced switches merged with PS2-held keys,
// plus a per-player latched movement direction for the processor.

module player_dir_lane #(
    parameter int STICKY = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] held,
    output logic [1:0] code,
    output logic       valid,
    output logic       change
);
    logic [3:0] held_prev_d, held_prev_q, rise;
    logic [1:0] code_d, code_q;
    logic       valid_d, valid_q, change_d, change_q;

    // Priority up > right > down > left.
    function automatic logic [1:0] lowest(input logic [3:0] v);
        if (v[0])      lowest = 2'd0;
        else if (v[1]) lowest = 2'd1;
        else if (v[2]) lowest = 2'd2;
        else           lowest = 2'd3;
    endfunction

    always_comb begin
        held_prev_d = held;
        rise        = held & ~held_prev_q;
        code_d      = code_q;
        valid_d     = valid_q;
        if (rise != 4'b0) begin
            code_d  = lowest(rise);
            valid_d = 1'b1;
        end else if (!held[code_q]) begin
            if (held != 4'b0) code_d = lowest(held);
            else if (STICKY == 0) valid_d = 1'b0;
        end
        change_d = (code_d != code_q) || (valid_d && !valid_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held_prev_q <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            change_q    <= 1'b0;
        end else begin
            held_prev_q <= held_prev_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            change_q    <= change_d;
        end
    end

    assign code   = code_q;
    assign valid  = valid_q;
    assign change = change_q;
endmodule

module player_input_ctrl #(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int STICKY          = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4*NUM_PLAYERS-1:0] sw,
    input  logic                     ps2_key_pressed,
    input  logic [7:0]               ps2_key_data,
    output logic [4*NUM_PLAYERS-1:0] dir_held,
    output logic [2*NUM_PLAYERS-1:0] dir_code,
    output logic [NUM_PLAYERS-1:0]   dir_valid,
    output logic [NUM_PLAYERS-1:0]   dir_change
);
    localparam int NB = 4 * NUM_PLAYERS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] KEY_MASK = (NUM_PLAYERS >= 2) ? 8'hFF : 8'h0F;

    typedef enum logic [1:0] {PS2_IDLE, PS2_EXT, PS2_BRK, PS2_EXT_BRK} ps2_state_e;

    logic [NB-1:0]            sync1_d, sync1_q, sync2_d, sync2_q;
    logic [NB-1:0]            stable_d, stable_q;
    logic [NB-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [NB-1:0]            key_vec, dir_held_d, dir_held_q;
    logic [7:0]               keys_d, keys_q;
    ps2_state_e               state_d, state_q;

    function automatic logic [3:0] p0_map(input logic [7:0] b);
        case (b)
            8'h1D:   p0_map = 4'b0001;
            8'h23:   p0_map = 4'b0010;
            8'h1B:   p0_map = 4'b0100;
            8'h1C:   p0_map = 4'b1000;
            default: p0_map = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] p1_map(input logic [7:0] b);
        case (b)
            8'h75:   p1_map = 4'b0001;
            8'h74:   p1_map = 4'b0010;
            8'h72:   p1_map = 4'b0100;
            8'h6B:   p1_map = 4'b1000;
            default: p1_map = 4'b0000;
        endcase
    endfunction

    // Counter only runs while the synchronized input disagrees with the accepted value.
    always_comb begin
        sync1_d  = sw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int b = 0; b < NB; b++) begin
            if (sync2_q[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                stable_d[b] = sync2_q[b];
                cnt_d[b]    = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (ps2_key_pressed) begin
            state_d = PS2_IDLE;
            case (state_q)
                PS2_IDLE: begin
                    if (ps2_key_data == 8'hE0)      state_d = PS2_EXT;
                    else if (ps2_key_data == 8'hF0) state_d = PS2_BRK;
                    else keys_d[3:0] = keys_q[3:0] | p0_map(ps2_key_data);
                end
                PS2_EXT: begin
                    if (ps2_key_data == 8'hF0) state_d = PS2_EXT_BRK;
                    else keys_d[7:4] = keys_q[7:4] | p1_map(ps2_key_data);
                end
                PS2_BRK:     keys_d[3:0] = keys_q[3:0] & ~p0_map(ps2_key_data);
                PS2_EXT_BRK: keys_d[7:4] = keys_q[7:4] & ~p1_map(ps2_key_data);
                default:     state_d = PS2_IDLE;
            endcase
            keys_d = keys_d & KEY_MASK;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_key
        if (b < 8) begin : g_on
            assign key_vec[b] = keys_q[b];
        end else begin : g_off
            assign key_vec[b] = 1'b0;
        end
    end

    always_comb dir_held_d = stable_q | key_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            cnt_q      <= '0;
            keys_q     <= '0;
            state_q    <= PS2_IDLE;
            dir_held_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            keys_q     <= keys_d;
            state_q    <= state_d;
            dir_held_q <= dir_held_d;
        end
    end

    assign dir_held = dir_held_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        player_dir_lane #(.STICKY(STICKY)) u_lane (
            .clock  (clock),
            .reset  (reset),
            .held   (dir_held_q[4*p +: 4]),
            .code   (dir_code[2*p +: 2]),
            .valid  (dir_valid[p]),
            .change (dir_change[p])
        );
    end
endmodule

// File: tb/tb_player_input_ctrl.sv
// Directed bench for player_input_ctrl: a sticky and a non-sticky instance share stimulus.

module tb_player_input_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       pk;
    logic [7:0] kd;
    logic [7:0] held_s, held_n;
    logic [3:0] code_s, code_n;
    logic [1:0] valid_s, valid_n, chg_s, chg_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] sw;
        logic       pk;
        logic [7:0] kd;
        logic [7:0] held;
        logic [3:0] code;
        logic [1:0] valid;
        logic [1:0] chg;
    } vec_t;

    vec_t tab_b[$];
    vec_t tab_de[$];

    always #5 clock = ~clock;

    player_input_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .CNT_W(20), .STICKY(1)) dut (
        .clock(clock), .reset(reset), .sw(sw), .ps2_key_pressed(pk), .ps2_key_data(kd),
        .dir_held(held_s), .dir_code(code_s), .dir_valid(valid_s), .dir_change(chg_s)
    );

    player_input_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYCLES(4), .CNT_W(20), .STICKY(0)) dut_ns (
        .clock(clock), .reset(reset), .sw(sw), .ps2_key_pressed(pk), .ps2_key_data(kd),
        .dir_held(held_n), .dir_code(code_n), .dir_valid(valid_n), .dir_change(chg_n)
    );

    function automatic vec_t mk(input logic [7:0] s, input logic p, input logic [7:0] d,
                                input logic [7:0] h, input logic [3:0] c,
                                input logic [1:0] v, input logic [1:0] g);
        vec_t r;
        r.sw = s; r.pk = p; r.kd = d; r.held = h; r.code = c; r.valid = v; r.chg = g;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got={held,code,valid,chg}=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic run_tab(input string nm, input vec_t v);
        sw = v.sw; pk = v.pk; kd = v.kd;
        tick();
        pk = 1'b0;
        chk(nm, {held_s, code_s, valid_s, chg_s}, {v.held, v.code, v.valid, v.chg});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        // switch up held, key D pressed then released
        tab_b.push_back(mk(8'h01, 1, 8'h23, 8'h01, 4'b0000, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h03, 4'b0000, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h03, 4'b0001, 2'b01, 2'b01));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h03, 4'b0001, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 1, 8'hF0, 8'h03, 4'b0001, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 1, 8'h23, 8'h03, 4'b0001, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h01, 4'b0001, 2'b01, 2'b00));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h01, 4'b0000, 2'b01, 2'b01));
        tab_b.push_back(mk(8'h01, 0, 8'h00, 8'h01, 4'b0000, 2'b01, 2'b00));
        // A make (with typematic repeat) then break; sticky keeps left
        tab_de.push_back(mk(8'h00, 1, 8'h1C, 8'h00, 4'b0000, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h08, 4'b0000, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h1C, 8'h08, 4'b0011, 2'b01, 2'b01));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h08, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hF0, 8'h08, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h1C, 8'h08, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0011, 2'b01, 2'b00));
        // player 1 extended right, make then break
        tab_de.push_back(mk(8'h00, 1, 8'hE0, 8'h00, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h74, 8'h00, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h20, 4'b0011, 2'b01, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h20, 4'b0111, 2'b11, 2'b10));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h20, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hE0, 8'h20, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hF0, 8'h20, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h74, 8'h20, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0111, 2'b11, 2'b00));
        // E0 1D is unmapped; parser must be back in IDLE for the following S make
        tab_de.push_back(mk(8'h00, 1, 8'hE0, 8'h00, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h1D, 8'h00, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h1B, 8'h00, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h04, 4'b0111, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h04, 4'b0110, 2'b11, 2'b01));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h04, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hF0, 8'h04, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h1B, 8'h04, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0110, 2'b11, 2'b00));
        // player 1 up, so the later switch test starts from code 0
        tab_de.push_back(mk(8'h00, 1, 8'hE0, 8'h00, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h75, 8'h00, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h10, 4'b0110, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h10, 4'b0010, 2'b11, 2'b10));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h10, 4'b0010, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hE0, 8'h10, 4'b0010, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'hF0, 8'h10, 4'b0010, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 1, 8'h75, 8'h10, 4'b0010, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0010, 2'b11, 2'b00));
        tab_de.push_back(mk(8'h00, 0, 8'h00, 8'h00, 4'b0010, 2'b11, 2'b00));

        reset = 1'b1; sw = '0; pk = 1'b0; kd = '0;
        repeat (3) tick();
        chk("reset_sticky", {held_s, code_s, valid_s, chg_s}, 16'h0);
        chk("reset_nonsticky", {held_n, code_n, valid_n, chg_n}, 16'h0);
        reset = 1'b0;
        tick();

        // debounce latency: first sampling edge is e=0
        sw = 8'h01;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk($sformatf("debounce_e%0d", e), {held_s, code_s, valid_s, chg_s},
                {(e >= 6) ? 8'h01 : 8'h00, 4'b0000, (e >= 7) ? 2'b01 : 2'b00,
                 (e == 7) ? 2'b01 : 2'b00});
        end
        // 3-cycle glitch low must be filtered
        sw = 8'h00;
        for (int e = 0; e < 12; e++) begin
            if (e == 3) sw = 8'h01;
            tick();
            chk($sformatf("glitch_e%0d", e), {held_s, code_s, valid_s, chg_s},
                {8'h01, 4'b0000, 2'b01, 2'b00});
        end

        for (int i = 0; i < tab_b.size(); i++) run_tab($sformatf("sw_key_row%0d", i), tab_b[i]);

        // release switch: sticky keeps valid, non-sticky drops valid without a pulse
        sw = 8'h00;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk($sformatf("rel_sticky_e%0d", e), {held_s, code_s, valid_s, chg_s},
                {(e >= 6) ? 8'h00 : 8'h01, 4'b0000, 2'b01, 2'b00});
            chk($sformatf("rel_nonsticky_e%0d", e), {held_n, code_n, valid_n, chg_n},
                {(e >= 6) ? 8'h00 : 8'h01, 4'b0000, (e >= 7) ? 2'b00 : 2'b01, 2'b00});
        end

        for (int i = 0; i < tab_de.size(); i++) run_tab($sformatf("ps2_row%0d", i), tab_de[i]);

        // player 1 right and left rise together: right wins
        sw = 8'hA0;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk($sformatf("tie_sticky_e%0d", e), {held_s, code_s, valid_s, chg_s},
                {(e >= 6) ? 8'hA0 : 8'h00, (e >= 7) ? 4'b0110 : 4'b0010, 2'b11,
                 (e == 7) ? 2'b10 : 2'b00});
            chk($sformatf("tie_nonsticky_e%0d", e), {held_n, code_n, valid_n, chg_n},
                {(e >= 6) ? 8'hA0 : 8'h00, (e >= 7) ? 4'b0110 : 4'b0010,
                 (e >= 7) ? 2'b10 : 2'b00, (e == 7) ? 2'b10 : 2'b00});
        end
        sw = 8'h00;
        for (int e = 0; e <= 8; e++) begin
            tick();
            chk($sformatf("tie_rel_sticky_e%0d", e), {held_s, code_s, valid_s, chg_s},
                {(e >= 6) ? 8'h00 : 8'hA0, 4'b0110, 2'b11, 2'b00});
            chk($sformatf("tie_rel_nonsticky_e%0d", e), {held_n, code_n, valid_n, chg_n},
                {(e >= 6) ? 8'h00 : 8'hA0, 4'b0110, (e >= 7) ? 2'b00 : 2'b10, 2'b00});
        end

        // reset right after a break prefix; 1D (W = player 0 up, bit 0) must then be a make
        pk = 1'b1; kd = 8'hF0;
        tick();
        pk = 1'b0;
        reset = 1'b1;
        #2;
        chk("async_reset_sticky", {held_s, code_s, valid_s, chg_s}, 16'h0);
        chk("async_reset_nonsticky", {held_n, code_n, valid_n, chg_n}, 16'h0);
        tick();
        tick();
        chk("held_reset", {held_s, code_s, valid_s, chg_s}, 16'h0);
        reset = 1'b0;
        tick();
        pk = 1'b1; kd = 8'h1D;
        tick();
        pk = 1'b0;
        chk("post_reset_strobe", {held_s, code_s, valid_s, chg_s}, 16'h0);
        tick();
        chk("post_reset_held", {held_s, code_s, valid_s, chg_s}, {8'h01, 4'b0000, 2'b00, 2'b00});
        tick();
        chk("post_reset_latch", {held_s, code_s, valid_s, chg_s}, {8'h01, 4'b0000, 2'b01, 2'b01});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
